// File: rtl/ttt_turn_controller.sv
// ttt_turn_controller: debounced two-player tic-tac-toe move sequencer with win/draw detection
module ttt_turn_controller #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        button,
  input  logic [8:0]  switches,
  output logic [8:0]  change,
  output logic [17:0] board,
  output logic        turn,
  output logic        error,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic [8:0]  win_mask
);
  typedef enum logic [2:0] {IDLE, CHECK, PLACE, EVAL, DONE} state_t;
  localparam logic [71:0] LINES = {9'b001010100, 9'b100010001, 9'b100100100, 9'b010010010,
                                   9'b001001001, 9'b111000000, 9'b000111000, 9'b000000111};
  state_t state, next;
  logic b0, b1, db, db_q, press, valid;
  logic [CNT_W-1:0] cnt;
  logic [8:0] sel, own, full, wm;
  logic [1:0] mark;
  assign press = db & ~db_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      {b0, b1, db, db_q} <= '0;
      cnt <= '0;
      state <= IDLE;
      sel <= '0;
      board <= '0;
      turn <= 1'b0;
      game_over <= 1'b0;
      winner <= 2'b00;
      win_mask <= '0;
    end else begin
      b0 <= button;
      b1 <= b0;
      db_q <= db;
      if (b1 == db) cnt <= '0;
      else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db <= b1;
        cnt <= '0;
      end else cnt <= cnt + CNT_W'(1);
      state <= next;
      if (state == IDLE && press) sel <= switches;
      if (state == PLACE)
        for (int i = 0; i < 9; i++) if (sel[i]) board[2*i +: 2] <= mark;
      if (state == EVAL) begin
        if (|wm) begin
          winner <= mark;
          win_mask <= wm;
          game_over <= 1'b1;
        end else if (&full) begin
          winner <= 2'b11;
          game_over <= 1'b1;
        end else turn <= ~turn;
      end
    end
  end
  always_comb begin
    mark = turn ? 2'b10 : 2'b01;
    own = '0;
    full = '0;
    wm = '0;
    for (int i = 0; i < 9; i++) begin
      own[i] = board[2*i +: 2] == mark;
      full[i] = |board[2*i +: 2];
    end
    for (int k = 0; k < 8; k++)
      if ((own & LINES[9*k +: 9]) == LINES[9*k +: 9]) wm = wm | LINES[9*k +: 9];
    valid = $onehot(sel) && !(|(sel & full));
    change = state == PLACE ? sel : '0;
    error = state == CHECK && !valid;
    next = state;
    case (state)
      IDLE:    next = press ? CHECK : IDLE;
      CHECK:   next = valid ? PLACE : IDLE;
      PLACE:   next = EVAL;
      EVAL:    next = (|wm || &full) ? DONE : IDLE;
      default: next = DONE;
    endcase
  end
endmodule

// File: tb/tb_ttt_turn_controller.sv
// tb_ttt_turn_controller: randomized and directed checks of ttt_turn_controller against a game model
module tb_ttt_turn_controller;
  logic clk = 0, rst = 0, button = 0;
  logic [8:0] switches = '0;
  logic [8:0] change, win_mask;
  logic [17:0] board;
  logic turn, error, game_over;
  logic [1:0] winner;
  int checks = 0, errors = 0;
  int nc, ne, ec, ee;
  bit both;
  logic [8:0] lastchg;
  int mb[9];
  bit mt, mo;
  logic [1:0] mw;
  logic [8:0] mm;
  int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  ttt_turn_controller #(.DEBOUNCE_CYCLES(4), .CNT_W(18)) dut (
    .clk(clk), .rst(rst), .button(button), .switches(switches), .change(change), .board(board),
    .turn(turn), .error(error), .game_over(game_over), .winner(winner), .win_mask(win_mask)
  );
  always #5 clk = ~clk;
  task automatic model_reset();
    foreach (mb[i]) mb[i] = 0;
    mt = 0; mo = 0; mw = 0; mm = 0;
  endtask
  task automatic model_press(input logic [8:0] s);
    int idx = 0, m;
    bit won = 0, filled = 1;
    ec = 0; ee = 0;
    if (mo) return;
    for (int i = 0; i < 9; i++) if (s[i]) idx = i;
    if ($countones(s) != 1 || mb[idx] != 0) begin ee = 1; return; end
    m = mt ? 2 : 1;
    mb[idx] = m;
    ec = 1;
    for (int l = 0; l < 8; l++)
      if (mb[lines[l][0]] == m && mb[lines[l][1]] == m && mb[lines[l][2]] == m) begin
        won = 1;
        mm[lines[l][0]] = 1; mm[lines[l][1]] = 1; mm[lines[l][2]] = 1;
      end
    foreach (mb[i]) if (mb[i] == 0) filled = 0;
    if (won) begin mw = 2'(m); mo = 1; end
    else if (filled) begin mw = 2'b11; mo = 1; end
    else mt = !mt;
  endtask
  function automatic logic [17:0] exp_board();
    logic [17:0] b = '0;
    for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(mb[i]);
    return b;
  endfunction
  task automatic sample();
    @(negedge clk);
    if (change != 0) begin nc++; lastchg = change; end
    if (error) ne++;
    if (change != 0 && error) both = 1;
  endtask
  task automatic press(input logic [8:0] s, input bit bounce);
    nc = 0; ne = 0; both = 0; lastchg = '0;
    switches = s;
    if (bounce) begin
      button = 1; sample();
      button = 0; sample();
      button = 1; sample();
    end
    button = 1;
    repeat (12) sample();
    button = 0;
    repeat (8) sample();
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1; button = 0; switches = '0;
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
  endtask
  task automatic test_reset();
    do_reset();
    checks += 7;
    if (board !== 18'd0) begin errors++; $display("FAIL reset_board got %h want 0", board); end
    if (turn !== 1'b0) begin errors++; $display("FAIL reset_turn got %b want 0", turn); end
    if (winner !== 2'b00) begin errors++; $display("FAIL reset_winner got %b want 00", winner); end
    if (game_over !== 1'b0) begin errors++; $display("FAIL reset_over got %b want 0", game_over); end
    if (change !== 9'd0) begin errors++; $display("FAIL reset_change got %b want 0", change); end
    if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", error); end
    if (win_mask !== 9'd0) begin errors++; $display("FAIL reset_mask got %b want 0", win_mask); end
  endtask
  task automatic test_place();
    do_reset();
    press(9'b000010000, 0);
    model_press(9'b000010000);
    checks += 6;
    if (nc != 1) begin errors++; $display("FAIL place_pulses got %0d want 1", nc); end
    if (lastchg !== 9'b000010000) begin errors++; $display("FAIL place_change got %b want 000010000", lastchg); end
    if (ne != 0) begin errors++; $display("FAIL place_error got %0d want 0", ne); end
    if (board[9:8] !== 2'b01) begin errors++; $display("FAIL place_square got %b want 01", board[9:8]); end
    if (turn !== 1'b1) begin errors++; $display("FAIL place_turn got %b want 1", turn); end
    if (board !== exp_board()) begin errors++; $display("FAIL place_board got %h want %h", board, exp_board()); end
  endtask
  task automatic test_reject();
    logic [8:0] bad[3] = '{9'b000000011, 9'b000000000, 9'b000010000};
    foreach (bad[k]) begin
      press(bad[k], 0);
      model_press(bad[k]);
      checks += 5;
      if (ne != 1 || ee != 1) begin errors++; $display("FAIL reject_error[%0d] got %0d want 1", k, ne); end
      if (nc != 0) begin errors++; $display("FAIL reject_change[%0d] got %0d want 0", k, nc); end
      if (both) begin errors++; $display("FAIL reject_overlap[%0d] got 1 want 0", k); end
      if (board !== exp_board()) begin errors++; $display("FAIL reject_board[%0d] got %h want %h", k, board, exp_board()); end
      if (turn !== 1'b1) begin errors++; $display("FAIL reject_turn[%0d] got %b want 1", k, turn); end
    end
  endtask
  task automatic test_win();
    int seq[5] = '{0, 1, 4, 2, 8};
    logic [17:0] held;
    do_reset();
    foreach (seq[k]) begin press(9'(1) << seq[k], 0); model_press(9'(1) << seq[k]); end
    checks += 5;
    if (winner !== 2'b01) begin errors++; $display("FAIL win_winner got %b want 01", winner); end
    if (win_mask !== 9'b100010001) begin errors++; $display("FAIL win_mask got %b want 100010001", win_mask); end
    if (game_over !== 1'b1) begin errors++; $display("FAIL win_over got %b want 1", game_over); end
    if (turn !== 1'b0) begin errors++; $display("FAIL win_turn got %b want 0", turn); end
    if (board !== exp_board()) begin errors++; $display("FAIL win_board got %h want %h", board, exp_board()); end
    held = exp_board();
    press(9'b001000000, 0);
    checks += 3;
    if (nc != 0 || ne != 0) begin errors++; $display("FAIL win_late_press got change=%0d error=%0d want 0/0", nc, ne); end
    if (board !== held) begin errors++; $display("FAIL win_late_board got %h want %h", board, held); end
    if (winner !== 2'b01) begin errors++; $display("FAIL win_late_winner got %b want 01", winner); end
  endtask
  task automatic test_draw();
    int seq[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    do_reset();
    foreach (seq[k]) begin press(9'(1) << seq[k], 0); model_press(9'(1) << seq[k]); end
    checks += 4;
    if (winner !== 2'b11) begin errors++; $display("FAIL draw_winner got %b want 11", winner); end
    if (win_mask !== 9'd0) begin errors++; $display("FAIL draw_mask got %b want 0", win_mask); end
    if (game_over !== 1'b1) begin errors++; $display("FAIL draw_over got %b want 1", game_over); end
    if (board !== exp_board()) begin errors++; $display("FAIL draw_board got %h want %h", board, exp_board()); end
  endtask
  task automatic test_bounce();
    do_reset();
    press(9'b000001000, 1);
    model_press(9'b000001000);
    checks += 2;
    if (nc != 1) begin errors++; $display("FAIL bounce_pulses got %0d want 1", nc); end
    if (board !== exp_board()) begin errors++; $display("FAIL bounce_board got %h want %h", board, exp_board()); end
  endtask
  task automatic test_reset_mid();
    int t = 0;
    do_reset();
    switches = 9'b000100000;
    button = 1;
    while (change == 0 && t < 30) begin @(negedge clk); t++; end
    checks++;
    if (change == 0) begin errors++; $display("FAIL midrst_timeout got no change want pulse"); end
    @(negedge clk);
    rst = 1; button = 0;
    @(negedge clk);
    checks += 3;
    if (board !== 18'd0 || turn !== 1'b0) begin errors++; $display("FAIL midrst_board got %h/%b want 0/0", board, turn); end
    if (winner !== 2'b00 || game_over !== 1'b0 || win_mask !== 9'd0) begin errors++; $display("FAIL midrst_result got %b/%b/%b want 0", winner, game_over, win_mask); end
    if (change !== 9'd0 || error !== 1'b0) begin errors++; $display("FAIL midrst_pulses got %b/%b want 0/0", change, error); end
    rst = 0;
    model_reset();
    repeat (10) @(negedge clk);
    checks++;
    if (board !== 18'd0 || turn !== 1'b0) begin errors++; $display("FAIL midrst_after got %h/%b want 0/0", board, turn); end
  endtask
  task automatic test_random();
    logic [8:0] s;
    for (int g = 0; g < 5; g++) begin
      do_reset();
      for (int p = 0; p < 16; p++) begin
        s = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'(1) << $urandom_range(0, 8);
        press(s, 0);
        model_press(s);
        checks += 6;
        if (nc != ec) begin errors++; $display("FAIL rand_change_count g%0d p%0d got %0d want %0d", g, p, nc, ec); end
        if (ec == 1 && lastchg !== s) begin errors++; $display("FAIL rand_change g%0d p%0d got %b want %b", g, p, lastchg, s); end
        if (ne != ee || both) begin errors++; $display("FAIL rand_error g%0d p%0d got %0d want %0d", g, p, ne, ee); end
        if (board !== exp_board()) begin errors++; $display("FAIL rand_board g%0d p%0d got %h want %h", g, p, board, exp_board()); end
        if (turn !== mt || game_over !== mo) begin errors++; $display("FAIL rand_turn_over g%0d p%0d got %b/%b want %b/%b", g, p, turn, game_over, mt, mo); end
        if (winner !== mw || win_mask !== mm) begin errors++; $display("FAIL rand_result g%0d p%0d got %b/%b want %b/%b", g, p, winner, win_mask, mw, mm); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_place();
    test_reject();
    test_win();
    test_draw();
    test_bounce();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
